// File: rtl/i_o_input_controller.sv
// i_o_input_controller: UART receive side of the I/O block.
// Deserialises 8N1 frames (start, 8 data bits LSB-first, stop) arriving on TXD
// into a one-byte holding register with a valid/ack handshake. Sticky
// framing-error and overrun flags are cleared by a one-cycle err_clear pulse.
module i_o_input_controller #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TXD,
  output logic [7:0] io_input_value,
  output logic       io_input_valid,
  input  logic       io_input_ack,
  input  logic       io_input_err_clear,
  output logic       io_input_frame_err,
  output logic       io_input_overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_CNT = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] ONE_CNT  = TW'(1);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;

  // Synchroniser and priming shift register
  logic          meta_q;
  logic          rxs_q;
  logic [1:0]    prime_q;

  // Receive FSM state
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;

  // Holding register and sticky flags
  logic [7:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic          deliver_s;
  logic          ferr_set_s;
  logic          ovr_set_s;

  // Two-flop synchroniser for TXD. The synchroniser resets to idle-high, so
  // for the first two cycles after reset rxs does not yet reflect the pin;
  // prime_q marks when it does, keeping WAIT_IDLE from being released by the
  // reset value while the real line is still held low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      prime_q <= 2'b00;
    end else begin
      meta_q  <= TXD;
      rxs_q   <= meta_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // Receive FSM: start detection, mid-bit sampling, stop-bit validation.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    deliver_s  = 1'b0;
    ferr_set_s = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (prime_q[1] && rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          timer_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // Resample the start bit at its centre to reject glitches.
        if (timer_q == HALF_CNT) begin
          timer_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end else begin
          timer_d = timer_q + ONE_CNT;
        end
      end
      S_DATA: begin
        if (timer_q == LAST_CNT) begin
          timer_d = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + ONE_CNT;
        end
      end
      S_STOP: begin
        if (timer_q == LAST_CNT) begin
          timer_d = '0;
          if (rxs_q) begin
            deliver_s = 1'b1;
            state_d   = S_IDLE;
          end else begin
            // Low stop bit: discard the byte and wait for the line to idle.
            ferr_set_s = 1'b1;
            state_d    = S_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + ONE_CNT;
        end
      end
      default: begin
        state_d = S_WAIT_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Holding register handshake and sticky error flags; a set beats a clear.
  always_comb begin
    value_d   = value_q;
    valid_d   = valid_q;
    ovr_set_s = 1'b0;
    if (deliver_s) begin
      if (!valid_q || io_input_ack) begin
        value_d = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_set_s = 1'b1;
      end
    end else if (valid_q && io_input_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (ferr_set_s) begin
      ferr_d = 1'b1;
    end else if (io_input_err_clear) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end

    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (io_input_err_clear) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      value_q   <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign io_input_value     = value_q;
  assign io_input_valid     = valid_q;
  assign io_input_frame_err = ferr_q;
  assign io_input_overrun   = ovr_q;

endmodule

// File: tb/tb_i_o_input_controller.sv
// Testbench for i_o_input_controller with 8-cycle bits. Expected bytes are
// queued when a frame is sent and compared when valid rises.
module tb_i_o_input_controller;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;

  logic       clk;
  logic       reset;
  logic       TXD;
  logic [7:0] io_input_value;
  logic       io_input_valid;
  logic       io_input_ack;
  logic       io_input_err_clear;
  logic       io_input_frame_err;
  logic       io_input_overrun;

  i_o_input_controller #(.CLKS_PER_BIT(CPB)) dut (
    .clk                (clk),
    .reset              (reset),
    .TXD                (TXD),
    .io_input_value     (io_input_value),
    .io_input_valid     (io_input_valid),
    .io_input_ack       (io_input_ack),
    .io_input_err_clear (io_input_err_clear),
    .io_input_frame_err (io_input_frame_err),
    .io_input_overrun   (io_input_overrun)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle;
    logic       exp_ferr;
    logic       exp_ovr;
    logic       exp_valid;
  } vec_t;

  int         tests_run = 0;
  int         fails = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = 0;
  int         deliveries = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  vec_t       vecs[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rising edge of valid must match the oldest queued byte.
  always @(negedge clk) begin
    if (io_input_valid && !prev_valid) begin
      rise_cyc = cyc;
      deliveries++;
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL sb_unexpected: got byte 0x%02h, required no delivery", io_input_value);
      end else begin
        check("sb_value", {24'h0, io_input_value}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_valid = io_input_valid;
  end

  // All drivers start and end just after a rising edge.
  task automatic drive_bit(input logic b);
    TXD = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    TXD = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic from_neg;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack;
    io_input_ack = 1'b1;
    @(posedge clk);
    #1;
    io_input_ack = 1'b0;
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    TXD = 1'b1;
    io_input_ack = 1'b0;
    io_input_err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    to_neg();
    check("rst_value", {24'h0, io_input_value}, 32'h0);
    check("rst_valid", {31'h0, io_input_valid}, 32'h0);
    check("rst_ferr", {31'h0, io_input_frame_err}, 32'h0);
    check("rst_ovr", {31'h0, io_input_overrun}, 32'h0);
    from_neg();
    idle(5);

    // 1: 0xA5, valid one clk after stop sample, then ack clears it.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    to_neg();
    check("t1_valid", {31'h0, io_input_valid}, 32'h1);
    check("t1_value", {24'h0, io_input_value}, 32'hA5);
    check("t1_ferr", {31'h0, io_input_frame_err}, 32'h0);
    check("t1_ovr", {31'h0, io_input_overrun}, 32'h0);
    // 2 sync flops + 1 detect cycle + half bit + 9 full bits to stop sample.
    check("t1_latency", rise_cyc - start_cyc, 2 + 1 + HALF + 9 * CPB);
    from_neg();
    pulse_ack();
    to_neg();
    check("t1_ack_clears", {31'h0, io_input_valid}, 32'h0);
    from_neg();
    idle(4);

    // Table: ack held high; back-to-back, framing error, reception after error.
    vecs[0] = '{8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 4, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1'b1, 4, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 6, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h12, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    io_input_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle(vecs[i].idle);
      to_neg();
      check($sformatf("vec%0d_valid", i), {31'h0, io_input_valid}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_ferr", i), {31'h0, io_input_frame_err}, {31'h0, vecs[i].exp_ferr});
      check($sformatf("vec%0d_ovr", i), {31'h0, io_input_overrun}, {31'h0, vecs[i].exp_ovr});
      from_neg();
    end
    io_input_ack = 1'b0;

    // 3: overrun keeps first byte; err_clear clears both sticky flags.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(2);
    send_frame(8'hC3, 1'b1);
    to_neg();
    check("t3_valid", {31'h0, io_input_valid}, 32'h1);
    check("t3_value", {24'h0, io_input_value}, 32'h3C);
    check("t3_ovr", {31'h0, io_input_overrun}, 32'h1);
    from_neg();
    io_input_err_clear = 1'b1;
    @(posedge clk);
    #1;
    io_input_err_clear = 1'b0;
    to_neg();
    check("t3_clr_ovr", {31'h0, io_input_overrun}, 32'h0);
    check("t3_clr_ferr", {31'h0, io_input_frame_err}, 32'h0);
    check("t3_value_hold", {24'h0, io_input_value}, 32'h3C);
    from_neg();
    pulse_ack();
    to_neg();
    check("t3_ack_clears", {31'h0, io_input_valid}, 32'h0);
    from_neg();

    // 5: two-cycle glitch is rejected, following frame still received.
    io_input_ack = 1'b1;
    TXD = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(20);
    to_neg();
    check("t5_valid", {31'h0, io_input_valid}, 32'h0);
    check("t5_ferr", {31'h0, io_input_frame_err}, 32'h0);
    check("t5_ovr", {31'h0, io_input_overrun}, 32'h0);
    from_neg();
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(4);

    // 6: reset during data bit 4 with line held low across release.
    d0 = deliveries;
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    TXD = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    to_neg();
    check("t6_rst_valid", {31'h0, io_input_valid}, 32'h0);
    check("t6_rst_value", {24'h0, io_input_value}, 32'h0);
    from_neg();
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(10);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(4);
    to_neg();
    check("t6_one_byte", deliveries - d0, 1);
    check("t6_ferr", {31'h0, io_input_frame_err}, 32'h0);
    check("t6_ovr", {31'h0, io_input_overrun}, 32'h0);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
